spi_reg_writer: RTL and testbench



---
 rtl/spi_reg_writer.sv | 161 ++++++++++++++++
 tb/tb_spi_reg_writer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator for 16-bit register frames {rw, addr[6:0], data[7:0]}, MSB first.
// One command per valid/ready handshake; read data comes back with a one-cycle rsp_valid pulse.
module spi_reg_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  input  logic       cipo
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic        rw_q, rw_d;
  logic [7:0]  rx_q, rx_d;
  logic        ncs_q, ncs_d;
  logic        sclk_q, sclk_d;
  logic        copi_q, copi_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        cnt_done;

  assign cnt_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    rx_d        = rx_q;
    ncs_d       = ncs_q;
    sclk_d      = sclk_q;
    copi_d      = copi_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        ncs_d       = 1'b1;
        sclk_d      = 1'b0;
        copi_d      = 1'b0;
        cnt_d       = 8'd0;
        // cmd_ready_q gates acceptance, so the first idle cycle after reset never handshakes
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          tx_d        = {cmd_rw, cmd_addr, cmd_wdata};
          rw_d        = cmd_rw;
          rx_d        = 8'd0;
          bit_d       = 4'd0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          ncs_d       = 1'b0;
          copi_d      = cmd_rw;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_d = SHIFT;
          cnt_d   = 8'd0;
        end
      end
      SHIFT: begin
        if (cnt_done) begin
          cnt_d  = 8'd0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[6:0], cipo};
          end else if (bit_q == 4'd15) begin
            copi_d  = 1'b0;
            state_d = HOLD;
          end else begin
            copi_d = tx_q[14];
            tx_d   = {tx_q[14:0], 1'b0};
            bit_d  = bit_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_d = GAP;
          cnt_d   = 8'd0;
          ncs_d   = 1'b1;
        end
      end
      GAP: begin
        if (cnt_done) begin
          state_d     = IDLE;
          cnt_d       = 8'd0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rw_q ? 8'h00 : rx_q;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 4'd0;
      tx_q        <= 16'd0;
      rw_q        <= 1'b0;
      rx_q        <= 8'd0;
      ncs_q       <= 1'b1;
      sclk_q      <= 1'b0;
      copi_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      rx_q        <= rx_d;
      ncs_q       <= ncs_d;
      sclk_q      <= sclk_d;
      copi_q      <= copi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ncs       = ncs_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer at CLK_DIV=4: frame bits, cycle timing, read data,
// back-to-back, busy-ignore and mid-frame reset, against hand-computed values.
module tb_spi_reg_writer;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, busy, sclk, copi, ncs;
  logic [7:0] rsp_rdata;
  logic       cipo = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_reg_writer #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor plus mode-0 target model; cipo changes after each falling sclk.
  logic [15:0] slv_word = 16'h0000;
  logic [15:0] copi_word = 16'h0000;
  logic [15:0] last_frame = 16'h0000;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
  int rise_cnt = 0, first_rise_cyc = 0, ncs_fall_cyc = 0, ncs_rise_cyc = 0;
  int rsp_cnt = 0, rsp_cyc = 0, rsp_cyc_prev = 0;
  logic [7:0] rsp_data = 8'h00;
  logic       rsp_busy = 1'b0;

  always @(negedge clk) begin
    if (prev_ncs && !ncs) begin
      ncs_fall_cyc = cyc;
      copi_word = 16'h0000;
      rise_cnt = 0;
      cipo = slv_word[15];
    end
    if (!prev_ncs && ncs) begin
      ncs_rise_cyc = cyc;
      last_frame = copi_word;
    end
    if (!prev_sclk && sclk) begin
      copi_word = {copi_word[14:0], copi};
      if (rise_cnt == 0) first_rise_cyc = cyc;
      rise_cnt++;
    end
    if (prev_sclk && !sclk && rise_cnt < 16) cipo = slv_word[15 - rise_cnt];
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc_prev = rsp_cyc;
      rsp_cyc = cyc;
      rsp_data = rsp_rdata;
      rsp_busy = busy;
    end
    prev_ncs = ncs;
    prev_sclk = sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int t0);
    t0 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        t0 = cyc;
        break;
      end
    end
    if (t0 < 0) chk("handshake_timeout", 0, 1);
  endtask

  task automatic do_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                        output int t0);
    @(posedge clk); #1;
    cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    wait_ready(t0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (rsp_cnt >= target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    int t0, t1, n0, rise1, rsp1;
    logic [15:0] f1;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 7'd0; cmd_wdata = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ncs", ncs, 1); chk("rst_sclk", sclk, 0); chk("rst_copi", copi, 0);
    chk("rst_ready", cmd_ready, 0); chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rdata", rsp_rdata, 8'h00);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", cmd_ready, 1);

    // Write 0x04 <- 0x80
    do_cmd(1'b1, 7'h04, 8'h80, t0);
    wait_rsp(1);
    chk("wr_frame", last_frame, 16'h8480);
    chk("wr_ncs_fall", ncs_fall_cyc - t0, 1);
    chk("wr_ncs_rise", ncs_rise_cyc - t0, 34 * D + 1);
    chk("wr_first_rise", first_rise_cyc - t0, 2 * D + 1);
    chk("wr_rsp_cyc", rsp_cyc - t0, 35 * D + 1);
    chk("wr_rdata", rsp_data, 8'h00);
    chk("wr_rsp_busy", rsp_busy, 0);
    @(negedge clk);
    chk("wr_rsp_pulse", rsp_valid, 0);

    // Read 0x02, target returns 0xA5 in the data byte
    slv_word = 16'h00A5;
    do_cmd(1'b0, 7'h02, 8'h5A, t0);
    wait_rsp(2);
    chk("rd_header", {16'h0, last_frame[15:8]}, 8'h02);
    chk("rd_rdata", rsp_data, 8'hA5);
    chk("rd_rsp_busy", rsp_busy, 0);
    chk("rd_rsp_cyc", rsp_cyc - t0, 35 * D + 1);
    repeat (5) @(negedge clk);
    chk("rd_rdata_hold", rsp_rdata, 8'hA5);
    slv_word = 16'h0000;

    // Back-to-back with cmd_valid held; the second command is presented while busy
    @(posedge clk); #1;
    cmd_rw = 1'b1; cmd_addr = 7'h00; cmd_wdata = 8'hFF; cmd_valid = 1'b1;
    wait_ready(t0);
    @(posedge clk); #1;
    cmd_addr = 7'h02; cmd_wdata = 8'h0F;
    wait_ready(t1);
    #1;
    chk("b2b_accept_cyc", t1 - t0, 35 * D + 1);
    f1 = last_frame; rise1 = ncs_rise_cyc; rsp1 = rsp_cyc;
    chk("b2b_frame1", f1, 16'h80FF);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(4);
    chk("b2b_ncs_gap", ncs_fall_cyc - rise1, D + 1);
    chk("b2b_rsp_gap", rsp_cyc - rsp1, 35 * D + 1);
    chk("b2b_frame2", last_frame, 16'h820F);
    chk("b2b_rdata", rsp_data, 8'h00);

    // Reset at the 8th sclk rise aborts the frame with no response
    do_cmd(1'b1, 7'h01, 8'h3C, t0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); #1;
        if (rise_cnt >= 8) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) chk("rst8_timeout", 0, 1);
    end
    n0 = rsp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ncs", ncs, 1); chk("abort_sclk", sclk, 0); chk("abort_copi", copi, 0);
    chk("abort_busy", busy, 0); chk("abort_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_ready_after", cmd_ready, 1);
    chk("abort_no_rsp", rsp_cnt, n0);

    do_cmd(1'b1, 7'h03, 8'hC3, t0);
    wait_rsp(n0 + 1);
    chk("post_rst_frame", last_frame, 16'h83C3);
    chk("post_rst_rsp_cyc", rsp_cyc - t0, 35 * D + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
